axis_frame_monitor: RTL

Synthesizable AXI-Stream sink that sits directly downstream of `system_top` and consumes its 64-bit `s_axis_tx_*` image stream. It drives `tready` with programmable backpressure and checks frame and line framing from `tuser`/`tlast`. It also counts lines and beats, accumulates a per-frame checksum, and exposes sticky error flags plus per-frame results to the bench or host.

---
 rtl/axis_frame_monitor_if.sv | 13 +
 rtl/axis_frame_monitor.sv | 112 +++++++++++
 2 files changed

// File: rtl/axis_frame_monitor_if.sv
// axis_frame_monitor_if: AXI-Stream channel between an image source and the frame monitor.
interface axis_frame_monitor_if #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 4
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tlast;
   modport master (output tvalid, tdata, tuser, tlast, input tready);
   modport slave (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_frame_monitor.sv
// axis_frame_monitor: AXI-Stream sink with programmable backpressure, frame/line checks, counters and checksum.
// Define AXIS_MON_STABLE_CHK_EN to compile in the stall-stability checker that drives err[5].
module axis_frame_monitor #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 aclk,
   input  logic                 aclk_reset_n,
   axis_frame_monitor_if.slave  s_axis,
   input  logic                 cfg_enable,
   input  logic [1:0]           cfg_bp_mode,
   input  logic [CNT_WIDTH-1:0] cfg_exp_lines,
   input  logic [CNT_WIDTH-1:0] cfg_exp_beats,
   input  logic                 clr,
   output logic                 frame_done,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [CNT_WIDTH-1:0] drop_cnt,
   output logic [CNT_WIDTH-1:0] last_lines,
   output logic [31:0]          last_checksum,
   output logic [5:0]           err
);
   typedef enum logic [1:0] {WAIT_SOF, LINE, GAP} state_t;
   state_t state, state_n;
   logic rdy, ph, beat, sof, eof, sol, eol, take, newline, eline, stable_err;
   logic [15:0] lfsr, lfsr_n;
   logic [CNT_WIDTH-1:0] beat_cnt, line_cnt, bc, lc;
   logic [31:0] checksum, sum, cs;
   logic [5:0] err_set;
   assign s_axis.tready = rdy;
   assign beat = s_axis.tvalid & rdy & ~clr;
   assign {eol, sol, eof, sof} = s_axis.tuser[3:0];
   assign lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   always_comb begin
      sum = '0;
      for (int i = 0; i < DATA_WIDTH / 32; i++) sum = sum + s_axis.tdata[32*i +: 32];
   end
   // SOF restarts from any state; the starting beat is processed as the first beat of a line
   always_comb begin
      take = sof | (state != WAIT_SOF);
      newline = sof | (state == GAP);
      eline = eol | eof;
      bc = newline ? CNT_WIDTH'(1) : beat_cnt + CNT_WIDTH'(beat_cnt != '1);
      cs = (sof ? 32'd0 : checksum) + sum;
      lc = (sof ? '0 : line_cnt) + CNT_WIDTH'(eline);
      state_n = state;
      if (beat && take) state_n = eof ? WAIT_SOF : (eol ? GAP : LINE);
      if (clr) state_n = WAIT_SOF;
      err_set = {stable_err, {5{beat}} & {
         (sof & ~sol) | ((state == GAP) & ~sof & ~sol),
         (take & eof & ~eol) | (s_axis.tlast != eol),
         take & eof & (lc != cfg_exp_lines),
         take & eline & (bc != cfg_exp_beats),
         sof & (state != WAIT_SOF)}};
   end
   always_ff @(posedge aclk) begin
      if (!aclk_reset_n) state <= WAIT_SOF;
      else state <= state_n;
   end
   always_ff @(posedge aclk) begin
      if (!aclk_reset_n) begin
         rdy <= 1'b0;
         ph <= 1'b0;
         lfsr <= 16'hACE1;
         beat_cnt <= '0;
         line_cnt <= '0;
         checksum <= '0;
         frame_done <= 1'b0;
         frame_cnt <= '0;
         drop_cnt <= '0;
         last_lines <= '0;
         last_checksum <= '0;
         err <= '0;
      end else begin
         lfsr <= lfsr_n;
         ph <= (cfg_enable && cfg_bp_mode == 2'd2) ? ~ph : 1'b0;
         rdy <= cfg_enable & ((cfg_bp_mode == 2'd0) | ((cfg_bp_mode == 2'd1) & (lfsr_n[0] | lfsr_n[1])) | ((cfg_bp_mode == 2'd2) & ~ph));
         frame_done <= beat & take & eof;
         err <= clr ? '0 : err | err_set;
         if (clr) begin
            frame_cnt <= '0;
            drop_cnt <= '0;
         end else if (beat && !take) begin
            drop_cnt <= drop_cnt + CNT_WIDTH'(drop_cnt != '1);
         end else if (beat) begin
            beat_cnt <= bc;
            line_cnt <= lc;
            checksum <= cs;
            if (eof) begin
               last_lines <= lc;
               last_checksum <= cs;
               frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end
`ifdef AXIS_MON_STABLE_CHK_EN
   logic pend, last_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [USER_WIDTH-1:0] user_q;
   always_ff @(posedge aclk) begin
      if (!aclk_reset_n) pend <= 1'b0;
      else pend <= s_axis.tvalid & ~rdy;
      data_q <= s_axis.tdata;
      user_q <= s_axis.tuser;
      last_q <= s_axis.tlast;
   end
   assign stable_err = pend & (~s_axis.tvalid | (s_axis.tdata != data_q) | (s_axis.tuser != user_q) | (s_axis.tlast != last_q));
`else
   assign stable_err = 1'b0;
`endif
endmodule
